// File: rtl/act_fetch_pkg.sv
// Shared definitions for the activation fetch stage: default widths,
// pass configuration record and a constant-width helper.
package act_fetch_pkg;

  localparam int ACT_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int SRAM_LAT_DEF   = 2;
  localparam int FIFO_DEPTH_DEF = 4;

  // Per-pass configuration as seen on the CFG_* inputs.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] base_addr;
    logic [ADDR_WIDTH_DEF-1:0] num_act;
  } pass_cfg_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/act_fetch_fifo.sv
// Small synchronous prefetch FIFO with flush, occupancy count and a
// fall-through head (head is valid whenever count is non-zero).
module act_fifo
  import act_fetch_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int PW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Storage write; a flush discards the word arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/act_fetch.sv
// Activation fetch stage: prefetches one pass of activations from SRAM into
// a credit-limited FIFO and hands them to CTRLACT one per request.
module act_fetch
  import act_fetch_pkg::*;
#(
  parameter int ACT_WIDTH  = ACT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SRAM_LAT   = SRAM_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  TOP_Sta,
  input  logic [ADDR_WIDTH-1:0] CFG_BaseAddr,
  input  logic [ADDR_WIDTH-1:0] CFG_NumAct,
  input  logic                  CTRLACT_PlsFetch,
  output logic                  CTRLACT_GetAct,
  output logic [ACT_WIDTH-1:0]  ACT_Data,
  input  logic                  PE_Rdy,
  output logic                  SRAM_RdEn,
  output logic [ADDR_WIDTH-1:0] SRAM_RdAddr,
  input  logic [ACT_WIDTH-1:0]  SRAM_RdData,
  output logic                  ACTFETCH_FnhPass,
  output logic                  ACTFETCH_Err
);

  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam int IW = clog2(SRAM_LAT + 1);

  logic                  active;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issued;     // one extra bit: may reach NumAct+1
  logic [ADDR_WIDTH-1:0] delivered;
  logic [SRAM_LAT-1:0]   pipe_vld;
  logic [CW-1:0]         pending;
  logic                  err;

  logic [CW-1:0]         fifo_cnt;
  logic [ACT_WIDTH-1:0]  fifo_head;
  logic [IW-1:0]         inflight;
  logic                  credit_ok;
  logic                  more_to_issue;
  logic                  rd_en;
  logic                  get_act;
  logic                  fnh;
  logic                  push;

  // Count reads still travelling through the SRAM latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) inflight = inflight + IW'(pipe_vld[i]);
  end

  // Reads are issued purely on FIFO credit, independent of outstanding requests.
  assign credit_ok     = (int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH;
  assign more_to_issue = issued <= {1'b0, CFG_NumAct};
  assign rd_en         = active && more_to_issue && credit_ok && !TOP_Sta;
  assign get_act       = !TOP_Sta && (fifo_cnt != '0) && (pending != '0) && PE_Rdy;
  assign fnh           = get_act && active && (delivered == CFG_NumAct);
  assign push          = pipe_vld[SRAM_LAT-1] && !TOP_Sta;

  // Latency pipe mirrors the SRAM read delay; a start drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst || TOP_Sta) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_en;
      for (int i = 1; i < SRAM_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Pass control: address/issue counters, delivered count and the active flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      rd_addr   <= '0;
      issued    <= '0;
      delivered <= '0;
    end else if (TOP_Sta) begin
      active    <= 1'b1;
      rd_addr   <= CFG_BaseAddr;
      issued    <= '0;
      delivered <= '0;
    end else begin
      if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        issued  <= issued + 1'b1;
      end
      if (get_act) delivered <= delivered + 1'b1;
      if (fnh)     active    <= 1'b0;
    end
  end

  // Outstanding-request counter; a start counts as the first request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else if (TOP_Sta) begin
      pending <= CW'(1);
    end else begin
      case ({CTRLACT_PlsFetch, get_act})
        2'b10: begin
          if (pending == CW'(FIFO_DEPTH)) err <= 1'b1;
          else                            pending <= pending + 1'b1;
        end
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  act_fifo #(
    .WIDTH (ACT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (TOP_Sta),
    .push      (push),
    .push_data (SRAM_RdData),
    .pop       (get_act),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign CTRLACT_GetAct   = get_act;
  assign ACT_Data         = get_act ? fifo_head : '0;
  assign SRAM_RdEn        = rd_en;
  assign SRAM_RdAddr      = rd_addr;
  assign ACTFETCH_FnhPass = fnh;
  assign ACTFETCH_Err     = err;

endmodule

// File: tb/tb_act_fetch.sv
// Directed bench for act_fetch: reset/start vector table plus pass, stall,
// restart, saturation and address-wrap sequences against an SRAM model.
module tb_act_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        top_sta = 1'b0;
  logic [11:0] cfg_base = '0;
  logic [11:0] cfg_num = '0;
  logic        pls_fetch = 1'b0;
  logic        get_act;
  logic [7:0]  act_data;
  logic        pe_rdy = 1'b0;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [7:0]  sram_rd_data = 8'hEE;
  logic        fnh;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [11:0] next_base = '0;
  logic [11:0] next_num = '0;

  logic [11:0] rd_log[$];
  logic [7:0]  get_log[$];
  int          get_cyc[$];
  int          fnh_cnt;
  int          fnh_idx;

  logic [11:0] exp_q[$];
  logic [7:0]  exp_data_q[$];

  act_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .TOP_Sta          (top_sta),
    .CFG_BaseAddr     (cfg_base),
    .CFG_NumAct       (cfg_num),
    .CTRLACT_PlsFetch (pls_fetch),
    .CTRLACT_GetAct   (get_act),
    .ACT_Data         (act_data),
    .PE_Rdy           (pe_rdy),
    .SRAM_RdEn        (rd_en),
    .SRAM_RdAddr      (rd_addr),
    .SRAM_RdData      (sram_rd_data),
    .ACTFETCH_FnhPass (fnh),
    .ACTFETCH_Err     (err)
  );

  // clock
  always #5 clk = ~clk;

  // SRAM content as a function of address
  function automatic logic [7:0] sram_word(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  // SRAM model, two-cycle read latency; idle cycles return a junk pattern
  logic        d1_vld = 1'b0;
  logic [11:0] d1_addr = '0;
  always @(posedge clk) begin
    d1_vld       <= rd_en;
    d1_addr      <= rd_addr;
    sram_rd_data <= d1_vld ? sram_word(d1_addr) : 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; top_sta = 1'b0; pls_fetch = 1'b0; pe_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    rd_log.delete(); get_log.delete(); get_cyc.delete();
    fnh_cnt = 0; fnh_idx = 0;
  endtask

  // One clock: drive at negedge, sample 1ns later; auto_pls models CTRLACT
  // re-requesting in every cycle an activation is delivered.
  task automatic do_cycle(input logic sta, input logic pls, input logic rdy, input logic auto_pls);
    @(negedge clk);
    top_sta = sta; pls_fetch = pls; pe_rdy = rdy;
    cfg_base = next_base; cfg_num = next_num;
    #1;
    if (auto_pls && get_act) pls_fetch = 1'b1;
    if (rd_en) rd_log.push_back(rd_addr);
    if (get_act) begin
      get_log.push_back(act_data);
      get_cyc.push_back(cyc);
    end
    if (fnh) begin
      fnh_cnt++;
      fnh_idx = get_log.size();
    end
    cyc++;
  endtask

  task automatic expect_pass(input logic [11:0] base, input int num);
    logic [11:0] a;
    exp_q.delete(); exp_data_q.delete();
    for (int i = 0; i <= num; i++) begin
      a = base + 12'(i);
      exp_q.push_back(a);
      exp_data_q.push_back(sram_word(a));
    end
  endtask

  task automatic check_logs(input string tag);
    check($sformatf("%s read count", tag), 32'(rd_log.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < rd_log.size()) check($sformatf("%s read addr %0d", tag, i), 32'(rd_log[i]), 32'(exp_q[i]));
    check($sformatf("%s get count", tag), 32'(get_log.size()), 32'(exp_data_q.size()));
    foreach (exp_data_q[i])
      if (i < get_log.size()) check($sformatf("%s act data %0d", tag, i), 32'(get_log[i]), 32'(exp_data_q[i]));
    check($sformatf("%s fnh count", tag), 32'(fnh_cnt), 32'd1);
    check($sformatf("%s fnh position", tag), 32'(fnh_idx), 32'(exp_data_q.size()));
  endtask

  typedef struct {
    logic        rst, sta, pls, rdy;
    logic        exp_rd_en;
    logic [11:0] exp_addr;
    logic        exp_get;
    logic [7:0]  exp_data;
    logic        exp_fnh, exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int c0, rel;

    // reset with inputs toggling, then the first cycles of a pass at 0x100
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h101, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h102, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h103, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h104, 1'b0, 8'h00, 1'b0, 1'b0};

    cfg_base = 12'h100; cfg_num = 12'd7;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; top_sta = vecs[i].sta; pls_fetch = vecs[i].pls; pe_rdy = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d rd_en", i),    32'(rd_en),    32'(vecs[i].exp_rd_en));
      check($sformatf("vec%0d rd_addr", i),  32'(rd_addr),  32'(vecs[i].exp_addr));
      check($sformatf("vec%0d get_act", i),  32'(get_act),  32'(vecs[i].exp_get));
      check($sformatf("vec%0d act_data", i), 32'(act_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d fnh", i),      32'(fnh),      32'(vecs[i].exp_fnh));
      check($sformatf("vec%0d err", i),      32'(err),      32'(vecs[i].exp_err));
    end

    // full pass, base 0x100, 8 activations
    next_base = 12'h100; next_num = 12'd7;
    do_reset(); clear_logs();
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    c0 = cyc - 1;
    repeat (24) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    expect_pass(12'h100, 7);
    check_logs("pass");
    check("pass first get latency", 32'((get_cyc.size() != 0) ? get_cyc[0] - c0 : -1), 32'd4);

    // consumer stalled for 10 cycles after start
    do_reset(); clear_logs();
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("stall reads outstanding", 32'(rd_log.size()), 32'd4);
    check("stall gets", 32'(get_log.size()), 32'd0);
    rel = cyc;
    repeat (24) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("stall first get cycle", 32'((get_cyc.size() >= 4) ? get_cyc[0] : -1), 32'(rel));
    check("stall fourth get cycle", 32'((get_cyc.size() >= 4) ? get_cyc[3] : -1), 32'(rel + 3));
    expect_pass(12'h100, 7);
    check_logs("stall");

    // restart mid-pass with data both in the FIFO and in flight
    do_reset(); clear_logs();
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart reads before", 32'(rd_log.size()), 32'd4);
    clear_logs();
    next_base = 12'h200; next_num = 12'd3;
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    expect_pass(12'h200, 3);
    check_logs("restart");

    // pending saturation and sticky error
    next_base = 12'h100; next_num = 12'd0;
    do_reset(); clear_logs();
    repeat (4) do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("err after 4 requests", 32'(err), 32'd0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("err after 5 requests", 32'(err), 32'd1);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("err sticky over pass", 32'(err), 32'd1);
    check("single-act pass gets", 32'(get_log.size()), 32'd1);
    check("single-act pass fnh", 32'(fnh_cnt), 32'd1);
    do_reset();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("err cleared by reset", 32'(err), 32'd0);

    // address wrap at the top of the SRAM
    next_base = 12'hFFE; next_num = 12'd3;
    do_reset(); clear_logs();
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (16) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    expect_pass(12'hFFE, 3);
    check_logs("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
